// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller at the ID/EX boundary.
// Drives EX forwarding selects, load-use and mul/div stalls, and a stall counter.
module hazard_forward_ctrl #(
  parameter int AW     = 5,
  parameter int NSRC   = 2,
  parameter int MD_LAT = 4,
  parameter int CW     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NSRC*AW-1:0] ARS_EX,
  input  logic [NSRC*AW-1:0] ARS_ID,
  input  logic [NSRC-1:0]   USE_ID,
  input  logic              MD_ID,
  input  logic [AW-1:0]     ARD_EX,
  input  logic              REGWRITE_EX,
  input  logic              MEMREAD_EX,
  input  logic [AW-1:0]     ARD_EX_MEM,
  input  logic              REGWRITE_EX_MEM,
  input  logic [AW-1:0]     ARD_MEM_WB,
  input  logic              REGWRITE_MEM_WB,
  input  logic              MD_START,
  output logic [NSRC*2-1:0] FORWARD,
  output logic              STALL,
  output logic              BUBBLE,
  output logic              MD_BUSY,
  output logic              MD_WB,
  output logic [AW-1:0]     MD_RD,
  output logic [CW-1:0]     STALL_CNT
);

  localparam int CNTW = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } md_state_e;

  md_state_e       state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   md_rd_q, md_rd_d;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;

  logic [NSRC*2-1:0] fwd;
  logic              ld_use;
  logic              md_haz;
  logic              stall;

  always_comb begin
    fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (REGWRITE_EX_MEM && ARD_EX_MEM != '0 &&
          ARD_EX_MEM == ARS_EX[i*AW +: AW]) begin
        fwd[i*2 +: 2] = 2'b10;
      end else if (REGWRITE_MEM_WB && ARD_MEM_WB != '0 &&
                   ARD_MEM_WB == ARS_EX[i*AW +: AW]) begin
        fwd[i*2 +: 2] = 2'b01;
      end
    end
  end

  always_comb begin
    ld_use = 1'b0;
    md_haz = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (USE_ID[i] && ARS_ID[i*AW +: AW] == ARD_EX)
        ld_use = 1'b1;
      if (USE_ID[i] && md_rd_q != '0 && ARS_ID[i*AW +: AW] == md_rd_q)
        md_haz = 1'b1;
    end
    ld_use = ld_use && MEMREAD_EX && REGWRITE_EX && ARD_EX != '0;
    md_haz = (state_q != S_IDLE) && (md_haz || MD_ID);
    stall  = ld_use || md_haz;
  end

  // A start seen outside IDLE is dropped; the unit is single-issue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_rd_d = md_rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (MD_START) begin
          state_d = S_BUSY;
          cnt_d   = CNTW'(MD_LAT - 2);
          md_rd_d = ARD_EX;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      md_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_rd_q     <= md_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FORWARD   = fwd;
  assign STALL     = stall;
  assign BUBBLE    = stall;
  assign MD_BUSY   = (state_q != S_IDLE);
  assign MD_WB     = (state_q == S_DONE);
  assign MD_RD     = md_rd_q;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed steps plus random traffic
// checked against a cycle-indexed reference model.
module tb_hazard_forward_ctrl;

  localparam int AW     = 5;
  localparam int NSRC   = 2;
  localparam int MD_LAT = 4;
  localparam int CW     = 8;
  localparam int MAXC   = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSRC*AW-1:0] ars_ex, ars_id;
  logic [NSRC-1:0]   use_id;
  logic              md_id;
  logic [AW-1:0]     ard_ex, ard_em, ard_mw;
  logic              we_ex, mr_ex, we_em, we_mw, md_start;
  logic [NSRC*2-1:0] forward;
  logic              stall, bubble, md_busy, md_wb;
  logic [AW-1:0]     md_rd;
  logic [CW-1:0]     stall_cnt;

  int total = 0;
  int bad   = 0;

  // model: cycle index since reset, start cycle of last accepted op
  int          cyc;
  int          t0;
  logic [AW-1:0] m_rd;
  int          m_cnt;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(
    .AW(AW), .NSRC(NSRC), .MD_LAT(MD_LAT), .CW(CW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .ARS_EX(ars_ex),
    .ARS_ID(ars_id),
    .USE_ID(use_id),
    .MD_ID(md_id),
    .ARD_EX(ard_ex),
    .REGWRITE_EX(we_ex),
    .MEMREAD_EX(mr_ex),
    .ARD_EX_MEM(ard_em),
    .REGWRITE_EX_MEM(we_em),
    .ARD_MEM_WB(ard_mw),
    .REGWRITE_MEM_WB(we_mw),
    .MD_START(md_start),
    .FORWARD(forward),
    .STALL(stall),
    .BUBBLE(bubble),
    .MD_BUSY(md_busy),
    .MD_WB(md_wb),
    .MD_RD(md_rd),
    .STALL_CNT(stall_cnt)
  );

  function automatic logic [AW-1:0] src(logic [NSRC*AW-1:0] b, int i);
    return b[i*AW +: AW];
  endfunction

  function automatic logic [NSRC*2-1:0] m_fwd();
    logic [NSRC*2-1:0] r;
    logic [AW-1:0] a;
    r = '0;
    for (int i = 0; i < NSRC; i++) begin
      a = src(ars_ex, i);
      if (a == 0) continue;
      if (we_em && ard_em == a)      r[i*2 +: 2] = 2'b10;
      else if (we_mw && ard_mw == a) r[i*2 +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic bit m_busy();
    return !rst && cyc > t0 && cyc <= t0 + MD_LAT;
  endfunction

  function automatic bit m_stall();
    bit lu, dh;
    lu = 0;
    dh = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (use_id[i] && src(ars_id, i) == ard_ex) lu = 1;
      if (use_id[i] && m_rd != 0 && src(ars_id, i) == m_rd) dh = 1;
    end
    lu = lu && mr_ex && we_ex && ard_ex != 0;
    return lu || (m_busy() && (md_id || dh));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    cyc   = 0;
    t0    = -100;
    m_rd  = '0;
    m_cnt = 0;
  endtask

  task automatic check_all(string tag);
    bit s;
    s = m_stall();
    chk({tag, ":fwd"}, 32'(forward), 32'(m_fwd()));
    chk({tag, ":stall"}, 32'(stall), 32'(s));
    chk({tag, ":bubble"}, 32'(bubble), 32'(s));
    chk({tag, ":busy"}, 32'(md_busy), 32'(m_busy()));
    chk({tag, ":wb"}, 32'(md_wb),
        32'(!rst && cyc == t0 + MD_LAT));
    chk({tag, ":rd"}, 32'(md_rd), 32'(m_rd));
    chk({tag, ":cnt"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic step(string tag);
    bit s, b;
    @(negedge clk);
    check_all(tag);
    s = m_stall();
    b = m_busy();
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      if (s && m_cnt < MAXC) m_cnt++;
      if (md_start && !b) begin
        t0   = cyc;
        m_rd = ard_ex;
      end
      cyc++;
    end
    #1;
  endtask

  task automatic idle_in();
    ars_ex   = '0;
    ars_id   = '0;
    use_id   = '0;
    md_id    = 1'b0;
    ard_ex   = '0;
    ard_em   = '0;
    ard_mw   = '0;
    we_ex    = 1'b0;
    mr_ex    = 1'b0;
    we_em    = 1'b0;
    we_mw    = 1'b0;
    md_start = 1'b0;
  endtask

  initial begin
    int c0;
    idle_in();
    rst = 1'b1;
    m_reset();
    step("reset");
    step("reset2");
    rst = 1'b0;
    step("post_reset");

    // forwarding priority
    ars_ex = {5'd3, 5'd3};
    ard_em = 5'd3; we_em = 1'b1;
    ard_mw = 5'd3; we_mw = 1'b1;
    #1 chk("fwd_em_prio", 32'(forward), 32'b1010);
    step("fwd_prio");
    we_em = 1'b0;
    #1 chk("fwd_mw", 32'(forward), 32'b0101);
    step("fwd_mw");

    // x0 and write-enable gating
    ars_ex = '0; ard_em = '0; we_em = 1'b1;
    ard_mw = '0; we_mw = 1'b1;
    #1 chk("fwd_x0", 32'(forward), 32'b0000);
    step("fwd_x0");
    ars_ex = {5'd5, 5'd5}; we_em = 1'b0;
    ard_mw = 5'd5; we_mw = 1'b0;
    #1 chk("fwd_we0", 32'(forward), 32'b0000);
    step("fwd_we0");
    idle_in();

    // load-use
    mr_ex = 1'b1; we_ex = 1'b1; ard_ex = 5'd7;
    ars_id = {5'd7, 5'd2}; use_id = 2'b10;
    #1 chk("ld_use", 32'(stall), 32'd1);
    step("ld_use");
    idle_in();
    step("ld_use_rel");
    mr_ex = 1'b1; we_ex = 1'b1; ard_ex = 5'd7;
    ars_id = {5'd7, 5'd2}; use_id = 2'b01;
    #1 chk("ld_nouse", 32'(stall), 32'd0);
    step("ld_nouse");
    idle_in();

    // multicycle op, dependent in ID reads x9
    c0 = m_cnt;
    md_start = 1'b1; ard_ex = 5'd9;
    ars_id = {5'd0, 5'd9}; use_id = 2'b01;
    step("md_c0");
    md_start = 1'b0; ard_ex = '0;
    for (int k = 1; k <= 4; k++) begin
      #1 chk("md_busy_win", 32'(md_busy), 32'd1);
      chk("md_stall_win", 32'(stall), 32'd1);
      chk("md_wb_c4", 32'(md_wb), 32'(k == 4));
      step("md_run");
    end
    chk("md_stall_rel", 32'(stall), 32'd0);
    chk("md_cnt4", 32'(stall_cnt), 32'(c0 + 4));
    step("md_c5");
    idle_in();

    // structural hazard and ignored start
    md_start = 1'b1; ard_ex = 5'd10;
    step("md2_start");
    md_start = 1'b1; ard_ex = 5'd12; md_id = 1'b1;
    #1 chk("md_struct", 32'(stall), 32'd1);
    step("md2_ign");
    md_start = 1'b0; md_id = 1'b0;
    chk("md_rd_kept", 32'(md_rd), 32'd10);
    step("md2_run");

    // async reset mid-busy
    idle_in();
    step("gap");
    md_start = 1'b1; ard_ex = 5'd9;
    ars_id = {5'd9, 5'd9}; use_id = 2'b11;
    step("md3_start");
    md_start = 1'b0;
    step("md3_c1");
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_rd", 32'(md_rd), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    step("rst_hold");
    rst = 1'b0;
    idle_in();
    step("rst_rel");

    // random traffic over a small register range to provoke matches
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NSRC; i++) begin
        ars_ex[i*AW +: AW] = AW'($urandom_range(0, 3));
        ars_id[i*AW +: AW] = AW'($urandom_range(0, 3));
      end
      use_id   = NSRC'($urandom);
      md_id    = ($urandom_range(0, 7) == 0);
      ard_ex   = AW'($urandom_range(0, 3));
      ard_em   = AW'($urandom_range(0, 3));
      ard_mw   = AW'($urandom_range(0, 3));
      we_ex    = 1'($urandom);
      mr_ex    = 1'($urandom);
      we_em    = 1'($urandom);
      we_mw    = 1'($urandom);
      md_start = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    // saturate the stall counter with a held load-use hazard
    idle_in();
    mr_ex = 1'b1; we_ex = 1'b1; ard_ex = 5'd7;
    ars_id = {5'd7, 5'd7}; use_id = 2'b11;
    for (int n = 0; n < MAXC + 10; n++) step("sat");
    chk("sat_ones", 32'(stall_cnt), 32'(MAXC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised hazard and forwarding controller for the pipelined RV32 core. Sits beside the ID/EX boundary. It generates per-source forwarding selects for the EX stage, load-use stalls for ID, and scoreboard stalls for a fixed-latency multicycle (mul/div) unit. It also keeps a saturating stall-cycle counter. It supersedes the two-source, forwarding-only unit.

## Interface
- AW, 5: register address width
- NSRC, 2: source operands per instruction (1..4); source i occupies bits [i*AW +: AW] of packed buses
- MD_LAT, 4: multicycle unit latency in cycles (>= 2)
- CW, 16: stall counter width

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- ARS_EX  in  NSRC*AW  source addresses of instruction in EX
- ARS_ID  in  NSRC*AW  source addresses of instruction in ID
- USE_ID  in  NSRC  source i of ID instruction is actually read
- MD_ID  in  1  ID instruction is a multicycle op
- ARD_EX, REGWRITE_EX, MEMREAD_EX  in  AW/1/1  destination, write enable, load flag of EX instruction
- ARD_EX_MEM, REGWRITE_EX_MEM  in  AW/1  EX/MEM destination and write enable
- ARD_MEM_WB, REGWRITE_MEM_WB  in  AW/1  MEM/WB destination and write enable
- MD_START  in  1  EX instruction issues to multicycle unit this cycle (destination = ARD_EX)
- FORWARD  out  NSRC*2  per-source select at [i*2 +: 2]: 00 register file, 10 EX/MEM, 01 MEM/WB
- STALL  out  1  hold PC and IF/ID
- BUBBLE  out  1  load NOP into ID/EX (equals STALL)
- MD_BUSY  out  1  multicycle unit occupied (state != IDLE)
- MD_WB  out  1  multicycle result written to register file this cycle
- MD_RD  out  AW  destination of outstanding multicycle op
- STALL_CNT  out  CW  saturating count of stall cycles

## Operation
- Forwarding, combinational, evaluated independently per source i. A producer stage matches when all of the following hold:
  - its REGWRITE is 1
  - its ARD is nonzero
  - its ARD equals the ARS_EX slice
- Forwarding priority: EX/MEM match gives 10, else MEM/WB match gives 01, else 00. Address 0 never forwards.
- Load-use hazard: MEMREAD_EX & REGWRITE_EX & ARD_EX!=0, and there is some i with USE_ID[i] & ARS_ID[i]==ARD_EX.
- Multicycle FSM states: IDLE, BUSY, DONE.
  - IDLE to BUSY on MD_START. Latch MD_RD=ARD_EX and load the counter with MD_LAT-2.
  - BUSY: counter decrements each cycle. When counter==0, go to DONE.
  - DONE: MD_WB=1, then go to IDLE.
  - MD_START when not IDLE is ignored; no state change.
- MD hazard: state != IDLE and either of the following:
  - MD_ID=1 (structural)
  - some i has USE_ID[i] & MD_RD!=0 & ARS_ID[i]==MD_RD (data)
- STALL = BUBBLE = load-use hazard OR MD hazard.
- STALL_CNT increments by 1 on each cycle with STALL=1 and saturates at all-ones.

## Timing
- FORWARD, STALL, BUBBLE: combinational from current inputs and registered state. No added latency.
- MD_START sampled at cycle t:
  - BUSY during t+1..t+MD_LAT-1
  - DONE (MD_WB=1) at t+MD_LAT
  - IDLE at t+MD_LAT+1
- A dependent in ID is released at t+MD_LAT+1, relying on the register file being write-before-read in DONE.
- A load-use stall lasts exactly 1 cycle. The load then moves to MEM and its result is forwarded from MEM/WB.
- Reset (asynchronous, any time, including mid-BUSY) forces:
  - state IDLE, counter 0
  - MD_RD=0, MD_WB=0, MD_BUSY=0
  - STALL_CNT=0
- FORWARD and STALL then follow inputs combinationally.
- Both hazards in the same cycle: single STALL. STALL_CNT increments once.

## Test plan
- Forward priority: ARS_EX src0=3, src1=3; EX/MEM rd=3 we=1; MEM/WB rd=3 we=1 -> FORWARD=1010. Set EX/MEM we=0 -> FORWARD=0101.
- x0 and write-enable gating: ARD_EX_MEM=0 we=1 and ARS_EX=0 -> FORWARD 00. ARD_MEM_WB=5 we=0 and ARS_EX=5 -> 00.
- Load-use: MEMREAD_EX=1, ARD_EX=7, ARS_ID src1=7, USE_ID=10 -> STALL=1 for one cycle. Repeat with USE_ID=01 -> STALL=0.
- Multicycle, MD_LAT=4: MD_START at cycle 0 with ARD_EX=9, ID reads x9.
  - MD_BUSY=1 for cycles 1-4
  - MD_WB=1 at cycle 4
  - STALL=1 for cycles 1-4, STALL=0 at cycle 5
  - STALL_CNT=4
- Structural and ignored start: MD_ID=1 during BUSY -> STALL=1. MD_START during BUSY leaves MD_RD unchanged.
- Reset mid-BUSY: assert RST at cycle 2 -> MD_BUSY=0, MD_RD=0, STALL_CNT=0 immediately, without waiting for a clock edge. Saturation: force 2^CW stall cycles -> STALL_CNT holds all-ones.
